// File: rtl/qsc_pkg.sv
// Shared constants for the multi-channel quadrature step counter:
// register offsets, ctrl/status bit positions and the decode direction.
package qsc_pkg;

    localparam logic [2:0] OFF_CNT_LO = 3'd0;
    localparam logic [2:0] OFF_SNAP   = 3'd1;
    localparam logic [2:0] OFF_LIM_LO = 3'd2;
    localparam logic [2:0] OFF_LIM_HI = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_CTRL   = 3'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_STOP   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_EN   = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DIR  = 2;
    localparam int ST_ERR  = 3;

    typedef enum logic {
        DIR_CW  = 1'b0,
        DIR_CCW = 1'b1
    } dir_e;

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: A/B synchroniser, 4x decoder, count/steps/limit/done/err.
// Latency: SYNC_FF cycles input-to-decode, +1 cycle to count/done. No backpressure; edges never stall.
module quad_channel
    import qsc_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int SYNC_FF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             wr_lim_lo,
    input  logic             wr_lim_hi,
    input  logic             wr_ctrl,
    input  logic [7:0]       wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] limit,
    output logic [7:0]       status,
    output logic [7:0]       ctrl,
    output logic             done,
    output logic             irq
);

    logic [SYNC_FF-1:0] r_sync_a;
    logic [SYNC_FF-1:0] r_sync_b;
    logic [1:0]         r_prev;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_steps;
    logic [CNT_W-1:0]   r_limit;
    logic [7:0]         r_stage;
    logic [3:0]         r_ctrl;
    logic               r_done;
    logic               r_err;
    dir_e               r_dir;

    logic [1:0]         w_curr;
    logic               w_inc;
    logic               w_dec;
    logic               w_ill;
    logic               w_run;
    logic               w_step;
    logic [CNT_W-1:0]   w_steps_nxt;
    logic [15:0]        w_lim16;

    assign w_curr  = {r_sync_a[SYNC_FF-1], r_sync_b[SYNC_FF-1]};
    assign w_lim16 = {wdata, r_stage};

    always_comb begin
        w_inc = 1'b0;
        w_dec = 1'b0;
        w_ill = 1'b0;
        case ({r_prev, w_curr})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_inc = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_dec = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_ill = 1'b1;
            default: ;
        endcase
    end

    // A pending clear swallows any edge in the same cycle; stop mode freezes after done.
    assign w_run       = r_ctrl[CTRL_EN] & ~r_ctrl[CTRL_CLR] & ~(r_ctrl[CTRL_STOP] & r_done);
    assign w_step      = w_run & (w_inc | w_dec);
    assign w_steps_nxt = (w_step && (r_steps != '1)) ? r_steps + 1'b1 : r_steps;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_prev   <= '0;
            r_count  <= '0;
            r_steps  <= '0;
            r_limit  <= '0;
            r_stage  <= '0;
            r_ctrl   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_dir    <= DIR_CW;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_FF-2:0], a};
            r_sync_b <= {r_sync_b[SYNC_FF-2:0], b};
            r_prev   <= w_curr;
            if (wr_lim_lo) r_stage <= wdata;
            if (wr_lim_hi) r_limit <= w_lim16[CNT_W-1:0];
            if (wr_ctrl) begin
                r_ctrl <= wdata[3:0];
            end else begin
                r_ctrl[CTRL_CLR] <= 1'b0;
            end
            if (r_ctrl[CTRL_CLR]) begin
                r_count <= '0;
                r_steps <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                if (w_step) begin
                    r_count <= w_inc ? r_count + 1'b1 : r_count - 1'b1;
                    r_dir   <= w_dec ? DIR_CCW : DIR_CW;
                end
                r_steps <= w_steps_nxt;
                if ((r_limit != '0) && (w_steps_nxt == r_limit)) r_done <= 1'b1;
                if (r_ctrl[CTRL_EN] && w_ill) r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        status               = '0;
        status[ST_EN]        = r_ctrl[CTRL_EN];
        status[ST_DONE]      = r_done;
        status[ST_DIR]       = (r_dir == DIR_CCW);
        status[ST_ERR]       = r_err;
    end

    assign count = r_count;
    assign limit = r_limit;
    assign ctrl  = {4'b0, r_ctrl};
    assign done  = r_done;
    assign irq   = (r_done | r_err) & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/quad_step_counter_mc.sv
// N-channel quadrature step counter with byte-wide register bus, coherent 16-bit reads and irq.
// Latency: read data registered, valid one cycle after cs&rd. No backpressure; bus always accepts.
module quad_step_counter_mc
    import qsc_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int SYNC_FF = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      addr,
    input  logic            cs,
    input  logic            rd,
    input  logic            wr,
    input  logic [7:0]      wdata,
    output logic [7:0]      data_out,
    input  logic [N_CH-1:0] a,
    input  logic [N_CH-1:0] b,
    output logic [N_CH-1:0] done,
    output logic            irq
);

    logic [4:0]       w_ch;
    logic [2:0]       w_off;
    logic             w_wr;
    logic             w_rd;
    logic [7:0]       w_rdata;
    logic [N_CH-1:0]  w_irq;
    logic [CNT_W-1:0] w_count  [N_CH];
    logic [CNT_W-1:0] w_limit  [N_CH];
    logic [15:0]      w_cnt16  [N_CH];
    logic [15:0]      w_lim16  [N_CH];
    logic [7:0]       w_status [N_CH];
    logic [7:0]       w_ctrl   [N_CH];
    logic [7:0]       r_snap   [N_CH];

    assign w_ch  = addr[7:3];
    assign w_off = addr[2:0];
    assign w_wr  = cs & wr;
    assign w_rd  = cs & rd & ~wr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic w_sel;
        assign w_sel = (w_ch == 5'(i));

        quad_channel #(
            .CNT_W   (CNT_W),
            .SYNC_FF (SYNC_FF)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .a         (a[i]),
            .b         (b[i]),
            .wr_lim_lo (w_wr & w_sel & (w_off == OFF_LIM_LO)),
            .wr_lim_hi (w_wr & w_sel & (w_off == OFF_LIM_HI)),
            .wr_ctrl   (w_wr & w_sel & (w_off == OFF_CTRL)),
            .wdata     (wdata),
            .count     (w_count[i]),
            .limit     (w_limit[i]),
            .status    (w_status[i]),
            .ctrl      (w_ctrl[i]),
            .done      (done[i]),
            .irq       (w_irq[i])
        );

        // Narrow counters read as zero-extended 16-bit values.
        assign w_cnt16[i] = 16'(w_count[i]);
        assign w_lim16[i] = 16'(w_limit[i]);
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch == 5'(i)) begin
                case (w_off)
                    OFF_CNT_LO: w_rdata = w_cnt16[i][7:0];
                    OFF_SNAP:   w_rdata = r_snap[i];
                    OFF_LIM_LO: w_rdata = w_lim16[i][7:0];
                    OFF_LIM_HI: w_rdata = w_lim16[i][15:8];
                    OFF_STATUS: w_rdata = w_status[i];
                    OFF_CTRL:   w_rdata = w_ctrl[i];
                    default:    w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            for (int i = 0; i < N_CH; i++) r_snap[i] <= '0;
        end else begin
            data_out <= w_rd ? w_rdata : 8'h00;
            for (int i = 0; i < N_CH; i++) begin
                if (w_rd && (w_off == OFF_CNT_LO) && (w_ch == 5'(i))) r_snap[i] <= w_cnt16[i][15:8];
            end
        end
    end

    assign irq = |w_irq;

endmodule

// File: tb/tb_quad_step_counter_mc.sv
// Bench for quad_step_counter_mc: directed scenarios then random traffic against a behavioural model.
module tb_quad_step_counter_mc;

    localparam int N_CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      addr;
    logic            cs, rd, wr;
    logic [7:0]      wdata;
    logic [7:0]      data_out;
    logic [N_CH-1:0] a, b;
    logic [N_CH-1:0] done;
    logic            irq;

    always #5 clk = ~clk;

    quad_step_counter_mc #(.N_CH(N_CH), .CNT_W(16), .SYNC_FF(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .cs(cs), .rd(rd), .wr(wr), .wdata(wdata),
        .data_out(data_out), .a(a), .b(b), .done(done), .irq(irq)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the register-visible state.
    logic [15:0] m_cnt   [N_CH];
    logic [15:0] m_steps [N_CH];
    logic [15:0] m_lim   [N_CH];
    logic [7:0]  m_stage [N_CH];
    logic [7:0]  m_snap  [N_CH];
    logic [7:0]  m_ctrl  [N_CH];
    logic        m_done  [N_CH];
    logic        m_err   [N_CH];
    logic        m_dir   [N_CH];
    int          phase   [N_CH];

    logic [7:0] exp_q[$];
    logic       rd_d = 1'b0;
    logic [7:0] e;

    always @(posedge clk) rd_d <= cs & rd & ~wr;

    always @(negedge clk) begin
        if (rd_d) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected data_out=%h with no read queued", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    miscompares++;
                    $display("FAIL rd_data got=%h want=%h", data_out, e);
                end
            end
        end else begin
            vectors++;
            if (data_out !== 8'h00) begin
                miscompares++;
                $display("FAIL idle_data got=%h want=00", data_out);
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = 0; m_steps[i] = 0; m_lim[i] = 0; m_stage[i] = 0; m_snap[i] = 0;
            m_ctrl[i] = 0; m_done[i] = 0; m_err[i] = 0; m_dir[i] = 0;
        end
    endfunction

    function automatic void model_limit_hit(int ch);
        if (m_lim[ch] != 0 && m_steps[ch] == m_lim[ch]) m_done[ch] = 1'b1;
    endfunction

    function automatic void model_edge(int ch, bit ccw);
        if (m_ctrl[ch][0] && !(m_ctrl[ch][2] && m_done[ch])) begin
            m_cnt[ch] = ccw ? m_cnt[ch] - 16'd1 : m_cnt[ch] + 16'd1;
            if (m_steps[ch] != 16'hFFFF) m_steps[ch] = m_steps[ch] + 16'd1;
            m_dir[ch] = ccw;
            model_limit_hit(ch);
        end
    endfunction

    function automatic void model_write(int ch, int off, logic [7:0] d);
        if (ch >= N_CH) return;
        case (off)
            2: m_stage[ch] = d;
            3: begin m_lim[ch] = {d, m_stage[ch]}; model_limit_hit(ch); end
            5: begin
                m_ctrl[ch] = {4'b0, d[3], d[2], 1'b0, d[0]};
                if (d[1]) begin
                    m_cnt[ch] = 0; m_steps[ch] = 0; m_done[ch] = 0; m_err[ch] = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] model_read(int ch, int off);
        if (ch >= N_CH) return 8'h00;
        case (off)
            0: begin m_snap[ch] = m_cnt[ch][15:8]; return m_cnt[ch][7:0]; end
            1: return m_snap[ch];
            2: return m_lim[ch][7:0];
            3: return m_lim[ch][15:8];
            4: return {4'b0, m_err[ch], m_dir[ch], m_done[ch], m_ctrl[ch][0]};
            5: return m_ctrl[ch];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [1:0] gray(int p);
        case (p & 3)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic drive_phase(int ch);
        logic [1:0] g;
        g = gray(phase[ch]);
        a[ch] = g[1];
        b[ch] = g[0];
    endtask

    task automatic bus_wr(int ch, int off, logic [7:0] d, bit also_rd = 1'b0);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = also_rd; addr = {5'(ch), 3'(off)}; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        model_write(ch, off, d);
    endtask

    task automatic bus_rd(int ch, int off);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = {5'(ch), 3'(off)};
        exp_q.push_back(model_read(ch, off));
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic edge_step(int ch, bit ccw);
        @(negedge clk);
        phase[ch] = ccw ? phase[ch] + 3 : phase[ch] + 1;
        drive_phase(ch);
        model_edge(ch, ccw);
        repeat (4) @(negedge clk);
    endtask

    task automatic illegal_step(int ch);
        @(negedge clk);
        phase[ch] = phase[ch] + 2;
        drive_phase(ch);
        if (m_ctrl[ch][0]) m_err[ch] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_limit(int ch, logic [15:0] lim);
        bus_wr(ch, 2, lim[7:0]);
        bus_wr(ch, 3, lim[15:8]);
    endtask

    task automatic check_pins(string tag);
        logic [N_CH-1:0] wd;
        logic            wi;
        wi = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            wd[i] = m_done[i];
            wi    = wi | ((m_done[i] | m_err[i]) & m_ctrl[i][3]);
        end
        repeat (2) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(wd));
        check({tag, "_irq"}, 32'(irq), 32'(wi));
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        a = '0; b = '0;
        for (int i = 0; i < N_CH; i++) phase[i] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_done", 32'(done), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus_rd(0, 0);
        bus_rd(0, 5);

        // Limit reached after exactly 20 CW edges, stop mode.
        set_limit(0, 16'd20);
        bus_wr(0, 5, 8'h05);
        for (int i = 0; i < 19; i++) edge_step(0, 1'b0);
        check_pins("t1_pre");
        edge_step(0, 1'b0);
        check_pins("t1_hit");
        bus_rd(0, 0);
        bus_rd(0, 4);

        // Counting continues past the limit without stop; negative count.
        bus_wr(1, 5, 8'h01);
        set_limit(1, 16'd8);
        for (int i = 0; i < 12; i++) edge_step(1, 1'b1);
        bus_rd(1, 0);
        bus_rd(1, 1);
        bus_rd(1, 4);
        check_pins("t2");

        // Stop mode freezes the count at the limit.
        bus_wr(3, 5, 8'h05);
        set_limit(3, 16'd8);
        for (int i = 0; i < 12; i++) edge_step(3, 1'b0);
        bus_rd(3, 0);
        bus_rd(3, 1);

        // Illegal double transition sets err and irq; clr removes both.
        bus_wr(2, 5, 8'h09);
        illegal_step(2);
        bus_rd(2, 4);
        bus_rd(2, 0);
        check_pins("t4_err");
        bus_wr(2, 5, 8'h0B);
        bus_rd(2, 4);
        check_pins("t4_clr");

        // Coherent read: snapshot keeps the high byte from the last low-byte read.
        bus_wr(2, 5, 8'h01);
        for (int i = 0; i < 255; i++) edge_step(2, 1'b0);
        bus_rd(2, 0);
        edge_step(2, 1'b0);
        bus_rd(2, 1);
        bus_rd(2, 0);
        bus_rd(2, 1);

        // clr in the same cycle as a decoded edge drops the edge.
        @(negedge clk);
        phase[1] = phase[1] + 1;
        drive_phase(1);
        bus_wr(1, 5, 8'h03);
        repeat (4) @(negedge clk);
        bus_rd(1, 0);
        for (int i = 0; i < 3; i++) edge_step(1, 1'b0);
        bus_rd(1, 0);

        // Read and write together: write lands, data_out stays 0.
        bus_wr(3, 5, 8'h01, 1'b1);
        bus_rd(3, 5);

        // Reset in the middle of motion.
        @(negedge clk);
        phase[0] = phase[0] + 1;
        drive_phase(0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_done", 32'(done), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        repeat (4) @(negedge clk);
        for (int c = 0; c < N_CH; c++)
            for (int o = 0; o < 6; o++) bus_rd(c, o);

        // Zero limit never sets done.
        bus_wr(0, 5, 8'h05);
        for (int i = 0; i < 10; i++) edge_step(0, 1'b0);
        bus_rd(0, 0);
        check_pins("t6_lim0");

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            int ch, r;
            ch = $urandom_range(0, N_CH - 1);
            r  = $urandom_range(0, 99);
            if (r < 55) begin
                edge_step(ch, 1'($urandom_range(0, 1)));
            end else if (r < 60) begin
                illegal_step(ch);
            end else if (r < 75) begin
                bus_rd($urandom_range(0, 7), $urandom_range(0, 7));
            end else if (r < 85) begin
                if ($urandom_range(0, 3) == 0)
                    set_limit(ch, 16'($urandom_range(0, 65535)));
                else
                    set_limit(ch, 16'($urandom_range(0, 40)));
            end else if (r < 95) begin
                logic [7:0] cv;
                cv = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) cv[1] = 1'b0;
                if ($urandom_range(0, 3) != 0) cv[0] = 1'b1;
                bus_wr(ch, 5, cv);
            end else begin
                if ($urandom_range(0, 1) == 1)
                    bus_wr(ch, $urandom_range(6, 7), 8'($urandom_range(0, 255)));
                else
                    bus_wr($urandom_range(N_CH, 31), $urandom_range(2, 5), 8'($urandom_range(0, 255)));
            end
            if ((it % 8) == 0) check_pins("rand");
        end
        for (int c = 0; c < N_CH; c++)
            for (int o = 0; o < 6; o++) bus_rd(c, o);
        check_pins("final");

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
